// File: rtl/nanov_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : nanov_pkg
//  Purpose  : Shared LED matrix geometry and scan state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package nanov_pkg;

  // Matrix geometry: one byte of rows per column.
  localparam int NANOV_LED_COLS = 4;
  localparam int NANOV_LED_ROWS = 8;

  // Scan state encoding.
  typedef enum logic [0:0] {
    LEDS_BLANK = 1'b0,
    LEDS_ON    = 1'b1
  } nanov_leds_state_t;

endpackage : nanov_pkg
`default_nettype wire

// File: rtl/nanov_led_matrix_driver.sv
`default_nettype none
// ============================================================================
//  Module   : nanov_led_matrix_driver
//  Purpose  : Scans a 4-column x 8-row LED matrix from the CPU output latch.
//             The word is double buffered, so the display only changes at a
//             frame boundary. Each column is preceded by a blanking gap, and a
//             global PWM brightness is applied during each column's ON phase.
//  Revision : 1.0  initial release
// ============================================================================
module nanov_led_matrix_driver
  import nanov_pkg::*;
#(
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 64,
  parameter int PWM_BITS     = 4
) (
  input  logic                      cpu_clk,
  input  logic                      rst,
  input  logic [31:0]               data_in,
  input  logic                      data_valid,
  input  logic [PWM_BITS-1:0]       brightness,
  output logic [NANOV_LED_ROWS-1:0] leds,
  output logic [NANOV_LED_COLS-1:0] lcol,
  output logic                      frame_sync
);

  // One counter serves both phases, so it is sized for the longer of the two.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int COL_W   = $clog2(NANOV_LED_COLS);

  localparam logic [CNT_W-1:0]          c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]          c_blank_last = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]          c_cnt_one    = CNT_W'(1);
  localparam logic [PWM_BITS-1:0]       c_pwm_one    = PWM_BITS'(1);
  localparam logic [COL_W-1:0]          c_col_one    = COL_W'(1);
  localparam logic [NANOV_LED_COLS-1:0] c_col_bit0   = NANOV_LED_COLS'(1);

  // The PWM counter must sweep its full range within one column dwell, and
  // at least one blank clock is needed for the anti-ghosting gap.
  if ((DWELL_CYCLES < (1 << PWM_BITS)) || (BLANK_CYCLES < 1)) begin : g_param_check
    $error("nanov_led_matrix_driver: illegal DWELL_CYCLES/BLANK_CYCLES/PWM_BITS");
  end

  nanov_leds_state_t           r_state, w_state_nxt;
  logic [COL_W-1:0]            r_col, w_col_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic [PWM_BITS-1:0]         r_pwm, w_pwm_nxt;

  logic [31:0]                 r_pending;
  logic                        r_pend_flag;
  logic [31:0]                 r_display;

  logic [NANOV_LED_ROWS-1:0]   r_leds, w_leds_nxt;
  logic [NANOV_LED_COLS-1:0]   r_lcol, w_lcol_nxt;
  logic                        r_frame_sync, w_frame_sync_nxt;

  logic [NANOV_LED_ROWS-1:0]   w_byte;
  logic                        w_frame_start;

  // A new frame begins on the last blank clock before column 0 turns on.
  assign w_frame_start = (r_state == LEDS_BLANK) && (r_cnt == c_blank_last) &&
                         (r_col == '0);

  // State register: scan phase, column, phase counter and PWM counter.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state <= LEDS_BLANK;
      r_col   <= '0;
      r_cnt   <= '0;
      r_pwm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pwm   <= w_pwm_nxt;
    end
  end

  // Next-state logic: BLANK for BLANK_CYCLES, then ON for DWELL_CYCLES, then next column.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt + c_cnt_one;
    w_pwm_nxt   = r_pwm + c_pwm_one;
    case (r_state)
      LEDS_BLANK: begin
        w_pwm_nxt = '0;
        if (r_cnt == c_blank_last) begin
          w_state_nxt = LEDS_ON;
          w_cnt_nxt   = '0;
        end
      end
      LEDS_ON: begin
        if (r_cnt == c_dwell_last) begin
          w_state_nxt = LEDS_BLANK;
          w_cnt_nxt   = '0;
          w_col_nxt   = r_col + c_col_one;
        end
      end
      default: begin
        w_state_nxt = LEDS_BLANK;
        w_cnt_nxt   = '0;
        w_pwm_nxt   = '0;
      end
    endcase
  end

  // Double buffer: capture strobes into pending, swap into display only at the frame boundary.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_display   <= '0;
    end else begin
      if (data_valid) begin
        r_pending   <= data_in;
        r_pend_flag <= 1'b1;
      end
      if (w_frame_start) begin
        if (data_valid) begin
          r_display <= data_in;
        end else if (r_pend_flag) begin
          r_display <= r_pending;
        end
        r_pend_flag <= 1'b0;
      end
    end
  end

  // Column byte select: column 0 shows the most significant byte.
  always_comb begin
    w_byte = r_display[7:0];
    case (r_col)
      2'd0:    w_byte = r_display[31:24];
      2'd1:    w_byte = r_display[23:16];
      2'd2:    w_byte = r_display[15:8];
      default: w_byte = r_display[7:0];
    endcase
  end

  // Output decode: everything dark in BLANK; in ON, enable the column and gate rows by PWM.
  always_comb begin
    w_leds_nxt       = '1;
    w_lcol_nxt       = '1;
    w_frame_sync_nxt = 1'b0;
    if (r_state == LEDS_ON) begin
      w_lcol_nxt       = ~(c_col_bit0 << r_col);
      w_frame_sync_nxt = (r_col == '0) && (r_cnt == '0);
      if (r_pwm <= brightness) begin
        w_leds_nxt = ~w_byte;
      end
    end
  end

  // Output registers: a reset forces the matrix dark on the very next edge.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_leds       <= '1;
      r_lcol       <= '1;
      r_frame_sync <= 1'b0;
    end else begin
      r_leds       <= w_leds_nxt;
      r_lcol       <= w_lcol_nxt;
      r_frame_sync <= w_frame_sync_nxt;
    end
  end

  assign leds       = r_leds;
  assign lcol       = r_lcol;
  assign frame_sync = r_frame_sync;

endmodule : nanov_led_matrix_driver
`default_nettype wire

// File: tb/tb_nanov_led_matrix_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nanov_led_matrix_driver
//  Purpose  : Self-checking bench for the LED matrix driver. A frame-position
//             model predicts leds/lcol/frame_sync every clock; directed
//             literal checks pin the model on known scan points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nanov_led_matrix_driver;

  localparam int D      = 32;
  localparam int B      = 4;
  localparam int P      = 2;
  localparam int SLOT   = B + D;
  localparam int PERIOD = 4 * SLOT;

  logic         cpu_clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  data_in = '0;
  logic         data_valid = 1'b0;
  logic [P-1:0] brightness = 2'd3;
  logic [7:0]   leds;
  logic [3:0]   lcol;
  logic         frame_sync;

  int n_vec = 0;
  int n_err = 0;
  int s_out = -1;

  nanov_led_matrix_driver #(
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B),
    .PWM_BITS     (P)
  ) u_dut (
    .cpu_clk    (cpu_clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .brightness (brightness),
    .leds       (leds),
    .lcol       (lcol),
    .frame_sync (frame_sync)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Model state: position in the frame (clocks since reset) plus buffers.
  int          m_s    = 0;
  logic [31:0] m_disp = '0;
  logic [31:0] m_pend = '0;
  bit          m_flag = 1'b0;
  bit          m_ok   = 1'b0;

  // Reference model: expected outputs from the frame position, compared 1 time unit after each edge.
  always begin : model
    logic [7:0] e_leds;
    logic [3:0] e_lcol;
    logic       e_fs;
    logic [7:0] e_byte;
    logic [3:0] one;
    bit         chk;
    int         p, c, o, j;
    @(posedge cpu_clk);
    chk    = 1'b0;
    e_leds = 8'hFF;
    e_lcol = 4'hF;
    e_fs   = 1'b0;
    if (rst) begin
      m_s = 0; m_disp = '0; m_pend = '0; m_flag = 1'b0; m_ok = 1'b1;
      chk = 1'b1;
    end else if (m_ok) begin
      chk = 1'b1;
      p = m_s % PERIOD;
      c = p / SLOT;
      o = p % SLOT;
      if (o >= B) begin
        j      = o - B;
        one    = 4'b0001;
        e_lcol = ~(one << c);
        e_byte = 8'(m_disp >> (8 * (3 - c)));
        if ((j % (1 << P)) <= int'(brightness)) e_leds = ~e_byte;
        e_fs = (c == 0) && (j == 0);
      end
      if (p == B - 1) begin
        if (data_valid) m_disp = data_in;
        else if (m_flag) m_disp = m_pend;
      end
      if (data_valid) begin
        m_pend = data_in;
        m_flag = 1'b1;
      end
      if (p == B - 1) m_flag = 1'b0;
      m_s++;
    end
    #1;
    if (chk) begin
      n_vec++;
      if (leds !== e_leds || lcol !== e_lcol || frame_sync !== e_fs) begin
        n_err++;
        $display("FAIL model t=%0t: leds=%h lcol=%h fs=%b, required leds=%h lcol=%h fs=%b",
                 $time, leds, lcol, frame_sync, e_leds, e_lcol, e_fs);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance falling edges until the displayed output belongs to scan clock t.
  task automatic goto(input int t);
    while (s_out < t) begin
      @(negedge cpu_clk);
      s_out++;
    end
  endtask

  // Count falling edges after reset release until frame_sync is seen (bounded).
  task automatic find_fs(output int k);
    bit found;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      @(negedge cpu_clk);
      k++;
      if (k == 1) data_valid = 1'b0;
      if (frame_sync === 1'b1) found = 1'b1;
    end
  endtask

  initial begin : stim
    int k;
    int on_cnt, en_cnt;

    // Reset held for 3 clocks.
    repeat (3) @(negedge cpu_clk);
    check("reset_leds", leds, 8'hFF);
    check("reset_lcol", lcol, 4'hF);
    check("reset_fs", frame_sync, 1'b0);

    // Release and strobe the first word before the first frame boundary.
    rst = 1'b0; data_valid = 1'b1; data_in = 32'h8142_2418;
    find_fs(k);
    check("first_fs_latency", k, 5);
    s_out = k - 1;
    check("col0_leds", leds, 8'h7E);
    check("col0_lcol", lcol, 4'hE);
    goto(36);
    check("gap01_lcol", lcol, 4'hF);
    goto(40);
    check("col1_leds", leds, 8'hBD);
    check("col1_lcol", lcol, 4'hD);
    goto(76);
    check("col2_leds", leds, 8'hDB);
    check("col2_lcol", lcol, 4'hB);

    // Tear-free: new word arrives mid-frame, must wait for the next frame.
    data_valid = 1'b1; data_in = 32'hFFFF_FFFF;
    goto(77);
    data_valid = 1'b0;
    goto(112);
    check("tear_col3_leds", leds, 8'hE7);
    check("tear_col3_lcol", lcol, 4'h7);
    goto(148);
    check("newframe_fs", frame_sync, 1'b1);
    check("newframe_leds", leds, 8'h00);

    // Simultaneous strobe on the boundary beats a pending word and clears it.
    goto(150);
    data_valid = 1'b1; data_in = 32'h1234_5678;
    goto(151);
    data_valid = 1'b0;
    goto(290);
    data_valid = 1'b1; data_in = 32'h0000_00A5;
    goto(291);
    data_valid = 1'b0;
    goto(292);
    check("bypass_fs", frame_sync, 1'b1);
    check("bypass_col0_leds", leds, 8'hFF);
    check("bypass_col0_lcol", lcol, 4'hE);
    goto(400);
    check("bypass_col3_leds", leds, 8'h5A);
    goto(544);
    check("pendclr_col3_leds", leds, 8'h5A);

    // PWM duty: brightness 1 then 0 on byte 0x01.
    goto(545);
    data_valid = 1'b1; data_in = 32'h0101_0101; brightness = 2'd1;
    goto(546);
    data_valid = 1'b0;
    on_cnt = 0; en_cnt = 0;
    for (int t = 580; t <= 611; t++) begin
      goto(t);
      if (leds[0] == 1'b0) on_cnt++;
      if (lcol == 4'hE) en_cnt++;
    end
    check("pwm_b1_on", on_cnt, 16);
    check("pwm_b1_en", en_cnt, 32);
    goto(612);
    brightness = 2'd0;
    on_cnt = 0; en_cnt = 0;
    for (int t = 616; t <= 647; t++) begin
      goto(t);
      if (leds[0] == 1'b0) on_cnt++;
      if (lcol == 4'hD) en_cnt++;
    end
    check("pwm_b0_on", on_cnt, 8);
    check("pwm_b0_en", en_cnt, 32);

    // Reset mid col1 ON with a pending word that must be dropped.
    goto(755);
    data_valid = 1'b1; data_in = 32'hDEAD_BEEF;
    goto(756);
    data_valid = 1'b0;
    goto(770);
    check("pre_rst_lcol", lcol, 4'hD);
    rst = 1'b1;
    @(negedge cpu_clk);
    check("midrst_leds", leds, 8'hFF);
    check("midrst_lcol", lcol, 4'hF);
    @(negedge cpu_clk);
    rst = 1'b0;
    find_fs(k);
    check("rst_fs_latency", k, 5);
    check("rst_col0_leds", leds, 8'hFF);
    check("rst_col0_lcol", lcol, 4'hE);

    // Randomized traffic with one short reset, checked by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge cpu_clk);
      data_valid = ($urandom_range(0, 15) == 0);
      data_in    = $urandom;
      brightness = 2'($urandom_range(0, 3));
      rst        = (i == 300);
    end
    @(negedge cpu_clk);
    data_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge cpu_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_nanov_led_matrix_driver
`default_nettype wire
